// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-addressed data memory between the core
// load/store path (requester 0) and a debug/loader port (requester 1).
// Bursts are bounded by MAX_BURST while the other side waits; read data is registered.
module dmem_arbiter #(
   parameter int unsigned AW        = 9,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic          req0_we,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_ready,
   output logic          req0_rvalid,
   output logic [DW-1:0] req0_rdata,
   input  logic          req1_valid,
   input  logic          req1_we,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_ready,
   output logic          req1_rvalid,
   output logic [DW-1:0] req1_rdata,
   output logic          core_stall,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [15:0]   conflict_cnt
);

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e        state_q;
   logic          last_owner_q;
   logic [3:0]    burst_q;
   logic [15:0]   conflict_q;
   logic          rvalid0_q, rvalid1_q;
   logic [DW-1:0] rdata0_q, rdata1_q;

   logic          gnt_vld;
   logic          gnt_sel;
   state_e        gnt_state;
   logic          burst_done;

   assign burst_done = (burst_q >= 4'(MAX_BURST));
   assign gnt_state  = gnt_sel ? StOwn1 : StOwn0;

   // Grant decision from registered state and the valids only; nothing granted in reset.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_sel = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StOwn0: begin
               if (req0_valid && !burst_done) begin
                  gnt_vld = 1'b1;
               end else if (req1_valid) begin
                  gnt_vld = 1'b1;
                  gnt_sel = 1'b1;
               end else if (req0_valid) begin
                  gnt_vld = 1'b1;
               end
            end
            StOwn1: begin
               if (req1_valid && !burst_done) begin
                  gnt_vld = 1'b1;
                  gnt_sel = 1'b1;
               end else if (req0_valid) begin
                  gnt_vld = 1'b1;
               end else if (req1_valid) begin
                  gnt_vld = 1'b1;
                  gnt_sel = 1'b1;
               end
            end
            default: begin
               if (req0_valid && req1_valid) begin
                  gnt_vld = 1'b1;
                  gnt_sel = ~last_owner_q;
               end else if (req0_valid || req1_valid) begin
                  gnt_vld = 1'b1;
                  gnt_sel = req1_valid;
               end
            end
         endcase
      end
   end

   // Memory port mux; idle port is driven to zero.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_vld) begin
         mem_we    = gnt_sel ? req1_we    : req0_we;
         mem_addr  = gnt_sel ? req1_addr  : req0_addr;
         mem_wdata = gnt_sel ? req1_wdata : req0_wdata;
      end
   end

   assign req0_ready   = gnt_vld & ~gnt_sel;
   assign req1_ready   = gnt_vld & gnt_sel;
   assign core_stall   = req0_valid & ~req0_ready;
   // A reset in the cycle after a read swallows that read's pulse.
   assign req0_rvalid  = rvalid0_q & ~rst;
   assign req1_rvalid  = rvalid1_q & ~rst;
   assign req0_rdata   = rdata0_q;
   assign req1_rdata   = rdata1_q;
   assign conflict_cnt = conflict_q;

   // Owner FSM, burst counter, conflict counter and registered read returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         last_owner_q <= 1'b1;
         burst_q      <= '0;
         conflict_q   <= '0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         if (req0_valid && req1_valid && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
         end
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         if (gnt_vld) begin
            state_q      <= gnt_state;
            last_owner_q <= gnt_sel;
            if ((state_q == gnt_state) && !burst_done) begin
               burst_q <= burst_q + 4'd1;
            end else begin
               burst_q <= 4'd1;
            end
            if (!mem_we) begin
               if (gnt_sel) begin
                  rvalid1_q <= 1'b1;
                  rdata1_q  <= mem_rdata;
               end else begin
                  rvalid0_q <= 1'b1;
                  rdata0_q  <= mem_rdata;
               end
            end
         end else begin
            state_q <= StIdle;
            burst_q <= '0;
         end
      end
   end

endmodule
